// File: rtl/sprite_lb_pkg.sv
// sprite_lb_pkg: shared definitions for the sprite line buffer display reader.
// Holds the buffer geometry, the reader FSM state encoding and the
// transparent pixel value used for both output masking and erasing.
package sprite_lb_pkg;

    localparam int LB_AW    = 9;
    localparam int PIX_W    = 8;
    localparam int LB_DEPTH = 1 << LB_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        ERASE = 2'd3
    } lb_state_e;

    localparam logic [7:0] TRANSPARENT = 8'h00;

endpackage

// File: rtl/linebuf_bank.sv
// linebuf_bank: one bank of the sprite line buffer.
// A (1<<AW) x DW RAM with one synchronous write port and one registered
// read port (data appears the cycle after the address is presented).
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address, sampled every clock
//   rdata  - registered read data
// RAM contents are intentionally not reset.
module linebuf_bank #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_r [0:DEPTH-1];
    logic [DW-1:0] rdata_r;

    // Storage array write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sprite_linebuf_reader.sv
// sprite_linebuf_reader: display-side end of the sprite double line buffer.
// The renderer writes the draw bank; this block reads the display bank at
// each pixel enable, outputs the pixel (masked to transparent when blanked
// or when its colour nibble is 0) and erases the location behind itself.
// Bank roles swap on line_sync, deferred to the end of an active sequence.
//
// Optional feature macro: SPR_LB_FLIP_EN -- when defined, screen_flip=1
// mirrors the read/erase address to ~hpix; otherwise screen_flip is ignored.
//
// Ports:
//   master_clk  - sole clock
//   nRESET      - synchronous active-low reset
//   pix_ce      - pixel enable, starts a read/latch/erase sequence
//   line_sync   - line start pulse, swaps bank roles
//   hpix        - horizontal pixel position, sampled on pix_ce
//   screen_flip - mirror read address (only with SPR_LB_FLIP_EN)
//   blank       - force pixel_out to transparent (erase still happens)
//   wr_en/wr_addr/wr_data - renderer write port into the draw bank
//   draw_bank   - bank owned by the renderer (0 = A)
//   pixel_out   - registered sprite pixel
//   pixel_valid - one-cycle strobe when pixel_out updates
//   overrun     - sticky flag: pix_ce arrived while busy
module sprite_linebuf_reader #(
    parameter int LB_AW = sprite_lb_pkg::LB_AW,
    parameter int PIX_W = sprite_lb_pkg::PIX_W
) (
    input  logic             master_clk,
    input  logic             nRESET,
    input  logic             pix_ce,
    input  logic             line_sync,
    input  logic [LB_AW-1:0] hpix,
    input  logic             screen_flip,
    input  logic             blank,
    input  logic             wr_en,
    input  logic [LB_AW-1:0] wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic             draw_bank,
    output logic [PIX_W-1:0] pixel_out,
    output logic             pixel_valid,
    output logic             overrun
);

    import sprite_lb_pkg::*;

    lb_state_e        state_r;
    lb_state_e        state_s;
    logic             draw_bank_r;
    logic             swap_pending_r;
    logic             overrun_r;
    logic [PIX_W-1:0] pixel_out_r;
    logic             pixel_valid_r;
    logic [LB_AW-1:0] rd_addr_r;
    logic [LB_AW-1:0] rd_addr_s;
    logic             start_s;
    logic             latch_s;
    logic             erase_we_s;
    logic             swap_now_s;

    logic             we_a_s;
    logic             we_b_s;
    logic [LB_AW-1:0] waddr_a_s;
    logic [LB_AW-1:0] waddr_b_s;
    logic [PIX_W-1:0] wdata_a_s;
    logic [PIX_W-1:0] wdata_b_s;
    logic [PIX_W-1:0] rdata_a_s;
    logic [PIX_W-1:0] rdata_b_s;
    logic [PIX_W-1:0] rd_data_s;

`ifdef SPR_LB_FLIP_EN
    // Read address: mirrored position when the screen is flipped.
    always_comb begin
        if (screen_flip) begin
            rd_addr_s = ~hpix;
        end else begin
            rd_addr_s = hpix;
        end
    end
`else
    logic unused_flip_s;
    assign unused_flip_s = screen_flip;
    assign rd_addr_s     = hpix;
`endif

    // FSM state register.
    always_ff @(posedge master_clk) begin
        if (!nRESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and per-state control strobes.
    always_comb begin
        state_s    = state_r;
        start_s    = 1'b0;
        latch_s    = 1'b0;
        erase_we_s = 1'b0;
        swap_now_s = 1'b0;
        case (state_r)
            IDLE: begin
                swap_now_s = line_sync;
                start_s    = pix_ce;
                if (pix_ce) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                latch_s = 1'b1;
                state_s = LATCH;
            end
            LATCH: begin
                state_s = ERASE;
            end
            ERASE: begin
                erase_we_s = 1'b1;
                // A line_sync landing in ERASE is folded into this swap.
                swap_now_s = swap_pending_r | line_sync;
                state_s    = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Bank ownership, deferred swap request and sticky overrun flag.
    always_ff @(posedge master_clk) begin
        if (!nRESET) begin
            draw_bank_r    <= 1'b0;
            swap_pending_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            if (swap_now_s) begin
                draw_bank_r    <= ~draw_bank_r;
                swap_pending_r <= 1'b0;
            end else if ((state_r != IDLE) && line_sync) begin
                swap_pending_r <= 1'b1;
            end
            if ((state_r != IDLE) && pix_ce) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // Capture the read/erase address at the start of a sequence.
    always_ff @(posedge master_clk) begin
        if (!nRESET) begin
            rd_addr_r <= '0;
        end else if (start_s) begin
            rd_addr_r <= rd_addr_s;
        end
    end

    // Bank write muxing: the draw bank takes renderer writes, the display bank takes erases.
    always_comb begin
        if (draw_bank_r) begin
            we_a_s    = erase_we_s;
            waddr_a_s = rd_addr_r;
            wdata_a_s = TRANSPARENT;
            we_b_s    = wr_en;
            waddr_b_s = wr_addr;
            wdata_b_s = wr_data;
            rd_data_s = rdata_a_s;
        end else begin
            we_a_s    = wr_en;
            waddr_a_s = wr_addr;
            wdata_a_s = wr_data;
            we_b_s    = erase_we_s;
            waddr_b_s = rd_addr_r;
            wdata_b_s = TRANSPARENT;
            rd_data_s = rdata_b_s;
        end
    end

    // Both banks are read with the live address; the RAM output register
    // holds the pixel by the time the FSM is in READ. draw_bank has already
    // taken any same-cycle swap, so rd_data_s selects the right bank.
    linebuf_bank #(.AW(LB_AW), .DW(PIX_W)) u_bank_a (
        .clk   (master_clk),
        .we    (we_a_s),
        .waddr (waddr_a_s),
        .wdata (wdata_a_s),
        .raddr (rd_addr_s),
        .rdata (rdata_a_s)
    );

    linebuf_bank #(.AW(LB_AW), .DW(PIX_W)) u_bank_b (
        .clk   (master_clk),
        .we    (we_b_s),
        .waddr (waddr_b_s),
        .wdata (wdata_b_s),
        .raddr (rd_addr_s),
        .rdata (rdata_b_s)
    );

    // Output pixel register with blank and colour-0 transparency masking.
    always_ff @(posedge master_clk) begin
        if (!nRESET) begin
            pixel_out_r   <= TRANSPARENT;
            pixel_valid_r <= 1'b0;
        end else begin
            pixel_valid_r <= latch_s;
            if (latch_s) begin
                if (blank || (rd_data_s[PIX_W-1 -: 4] == 4'h0)) begin
                    pixel_out_r <= TRANSPARENT;
                end else begin
                    pixel_out_r <= rd_data_s;
                end
            end
        end
    end

    assign draw_bank   = draw_bank_r;
    assign pixel_out   = pixel_out_r;
    assign pixel_valid = pixel_valid_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_sprite_linebuf_reader.sv
// Directed testbench for sprite_linebuf_reader.
module tb_sprite_linebuf_reader;

`ifdef SPR_LB_FLIP_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    logic       master_clk;
    logic       nRESET;
    logic       pix_ce;
    logic       line_sync;
    logic [8:0] hpix;
    logic       screen_flip;
    logic       blank;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic       draw_bank;
    logic [7:0] pixel_out;
    logic       pixel_valid;
    logic       overrun;

    int pass_cnt;
    int total_cnt;

    sprite_linebuf_reader dut (
        .master_clk  (master_clk),
        .nRESET      (nRESET),
        .pix_ce      (pix_ce),
        .line_sync   (line_sync),
        .hpix        (hpix),
        .screen_flip (screen_flip),
        .blank       (blank),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .draw_bank   (draw_bank),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .overrun     (overrun)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    task automatic step();
        @(posedge master_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic sync();
        line_sync = 1'b1;
        step();
        line_sync = 1'b0;
    endtask

    // Full read sequence; checks pixel at cycle 2 and returns in IDLE.
    task automatic read_px(input string tag, input logic [8:0] a, input logic [7:0] exp);
        pix_ce = 1'b1;
        hpix   = a;
        step();
        pix_ce = 1'b0;
        step();
        chk({tag, "_valid"}, {15'd0, pixel_valid}, 16'd1);
        chk(tag, {8'd0, pixel_out}, {8'd0, exp});
        step();
        step();
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        nRESET      = 1'b0;
        pix_ce      = 1'b0;
        line_sync   = 1'b0;
        hpix        = 9'd0;
        screen_flip = 1'b0;
        blank       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = 9'd0;
        wr_data     = 8'd0;
        step(); step(); step();
        chk("rst_draw_bank", {15'd0, draw_bank}, 16'd0);
        chk("rst_pixel_out", {8'd0, pixel_out}, 16'h0000);
        chk("rst_pixel_valid", {15'd0, pixel_valid}, 16'd0);
        chk("rst_overrun", {15'd0, overrun}, 16'd0);
        nRESET = 1'b1;
        step();

        // Basic read with latency and erase-after-read.
        wr(9'h010, 8'h5A);
        sync();
        chk("swap1_draw_bank", {15'd0, draw_bank}, 16'd1);
        pix_ce = 1'b1;
        hpix   = 9'h010;
        step();
        pix_ce = 1'b0;
        chk("lat_c1_valid", {15'd0, pixel_valid}, 16'd0);
        step();
        chk("lat_c2_valid", {15'd0, pixel_valid}, 16'd1);
        chk("lat_c2_pixel", {8'd0, pixel_out}, 16'h005A);
        step();
        chk("lat_c3_valid", {15'd0, pixel_valid}, 16'd0);
        chk("lat_c3_hold", {8'd0, pixel_out}, 16'h005A);
        step();
        read_px("erased_010", 9'h010, 8'h00);

        // Transparency and blanking, display bank B.
        wr(9'h020, 8'h07);
        wr(9'h030, 8'h93);
        wr(9'h040, 8'h93);
        sync();
        chk("swap2_draw_bank", {15'd0, draw_bank}, 16'd0);
        read_px("transp_020", 9'h020, 8'h00);
        read_px("opaque_040", 9'h040, 8'h93);
        blank = 1'b1;
        read_px("blank_030", 9'h030, 8'h00);
        blank = 1'b0;
        read_px("blank_erased_030", 9'h030, 8'h00);

        // Deferred swap with two line_sync pulses mid-sequence.
        wr(9'h080, 8'hC3);
        wr(9'h060, 8'h66);
        pix_ce = 1'b1;
        hpix   = 9'h020;
        step();
        pix_ce    = 1'b0;
        line_sync = 1'b1;
        step();
        chk("defer_pixel", {8'd0, pixel_out}, 16'h0000);
        step();
        line_sync = 1'b0;
        chk("defer_c3_draw", {15'd0, draw_bank}, 16'd0);
        step();
        chk("defer_c4_draw", {15'd0, draw_bank}, 16'd1);
        step(); step();
        chk("defer_once_draw", {15'd0, draw_bank}, 16'd1);

        // Overrun: second pix_ce during LATCH is ignored.
        chk("pre_overrun", {15'd0, overrun}, 16'd0);
        pix_ce = 1'b1;
        hpix   = 9'h060;
        step();
        pix_ce = 1'b0;
        step();
        chk("ovr_pixel", {8'd0, pixel_out}, 16'h0066);
        pix_ce = 1'b1;
        hpix   = 9'h070;
        step();
        pix_ce = 1'b0;
        chk("ovr_set", {15'd0, overrun}, 16'd1);
        step(); step();
        chk("ovr_no_second_read", {15'd0, pixel_valid}, 16'd0);
        step(); step(); step();
        chk("ovr_sticky", {15'd0, overrun}, 16'd1);

        // Renderer writes into B while A is displayed.
        pix_ce  = 1'b1;
        hpix    = 9'h080;
        wr_en   = 1'b1;
        wr_addr = 9'h080;
        wr_data = 8'h44;
        step();
        pix_ce  = 1'b0;
        wr_addr = 9'h000;
        wr_data = 8'h21;
        step();
        chk("conc_pixel", {8'd0, pixel_out}, 16'h00C3);
        wr_addr = 9'h1FF;
        wr_data = 8'h3F;
        step();
        wr_en = 1'b0;
        step();
        sync();
        chk("swap3_draw_bank", {15'd0, draw_bank}, 16'd0);
        read_px("conc_rb_080", 9'h080, 8'h44);
        screen_flip = 1'b1;
        read_px("flip_000", 9'h000, FLIP ? 8'h3F : 8'h21);
        screen_flip = 1'b0;
        read_px("flip_1ff_after", 9'h1FF, FLIP ? 8'h00 : 8'h3F);

        // line_sync and pix_ce together in IDLE: read uses the new display bank.
        wr(9'h0A0, 8'hB7);
        line_sync = 1'b1;
        pix_ce    = 1'b1;
        hpix      = 9'h0A0;
        step();
        line_sync = 1'b0;
        pix_ce    = 1'b0;
        chk("same_cyc_draw", {15'd0, draw_bank}, 16'd1);
        step();
        chk("same_cyc_pixel", {8'd0, pixel_out}, 16'h00B7);
        step(); step();

        // Reset clears the sticky flag and bank ownership.
        nRESET = 1'b0;
        step();
        chk("rst2_overrun", {15'd0, overrun}, 16'd0);
        chk("rst2_draw_bank", {15'd0, draw_bank}, 16'd0);
        chk("rst2_valid", {15'd0, pixel_valid}, 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sprite_linebuf_reader.md
# sprite_linebuf_reader

Display-side end of the sprite double line buffer. The sprite renderer writes the draw bank while this block scans the display bank in step with the horizontal pixel counter, outputs one 8-bit sprite pixel per pixel enable, and erases each location after reading so the bank is clean for the next draw pass. Bank roles swap on each line sync. The block sits between the sprite renderer and the final pixel mixer.

## Interface
Parameters:
- LB_AW, 9, line buffer address width (512 entries per bank)
- PIX_W, 8, pixel width: colour index in [7:4], palette select in [3:0]

Ports:
- master_clk  in  1  system clock; the only clock
- nRESET  in  1  synchronous, active-low reset
- pix_ce  in  1  one-cycle pixel enable; minimum spacing 4 master_clk
- line_sync  in  1  one-cycle pulse at line start; swaps bank roles
- hpix  in  LB_AW  current horizontal pixel position, sampled on pix_ce
- screen_flip  in  1  mirror the read address (see Configuration)
- blank  in  1  force pixel_out to 0; erase still performed
- wr_en  in  1  renderer write strobe into the draw bank
- wr_addr  in  LB_AW  renderer write address
- wr_data  in  PIX_W  renderer write data
- draw_bank  out  1  bank currently owned by the renderer (0 = A)
- pixel_out  out  PIX_W  registered sprite pixel; 0 = transparent
- pixel_valid  out  1  one-cycle strobe when pixel_out updates
- overrun  out  1  sticky: pix_ce arrived while the FSM was busy

## Operation
- Two banks, A and B. disp_bank = !draw_bank. Renderer writes go only to the draw bank; the reader touches only the display bank, so no port conflict exists.
- FSM states and transitions:
  - IDLE to READ on pix_ce.
  - READ: RAM read at rd_addr is in flight; then LATCH.
  - LATCH: pixel_out <= (blank or data[7:4]==0) ? 0 : data; pixel_valid = 1; then ERASE.
  - ERASE: write 0 to rd_addr in the display bank; then IDLE.
- rd_addr is registered on pix_ce: hpix, or the flipped address when flip is active.
- Transparent rule: a colour nibble of 0 outputs 8'h00 regardless of the palette nibble.
- line_sync in IDLE: toggle draw_bank in the same cycle. If line_sync and pix_ce arrive together in IDLE, the swap happens first and the read uses the new display bank.
- line_sync while not IDLE: set swap_pending and apply it on the ERASE-to-IDLE transition. A second line_sync while pending is absorbed, so only one toggle occurs.
- pix_ce while not IDLE: ignored and overrun set to 1. The in-flight sequence completes unchanged.
- Address arithmetic is modulo 2^LB_AW; there is no range check.

## Timing
- Reset values: draw_bank 0, pixel_out 0, pixel_valid 0, overrun 0, FSM IDLE, swap_pending 0. RAM contents are not cleared.
- Reset asserted mid-sequence: the FSM returns to IDLE and any pending erase is abandoned; that location keeps stale data until its next read.
- Latency: pix_ce at cycle 0; RAM address registered at cycle 1; pixel_out and pixel_valid at cycle 2; erase write at cycle 3; IDLE again at cycle 4.
- The RAM has a 1-cycle synchronous read. A renderer write is visible in the next cycle.
- draw_bank changes on the clock edge after line_sync is sampled in IDLE.

## Configuration
- SPR_LB_FLIP_EN defined: when screen_flip = 1, rd_addr = ~hpix (511 - hpix). The erase uses the same flipped address.
- SPR_LB_FLIP_EN undefined: screen_flip is ignored and rd_addr = hpix always.

## Structure
- Shared package sprite_lb_pkg holds:
  - LB_AW, PIX_W, LB_DEPTH (1 << LB_AW)
  - the FSM state enum (IDLE, READ, LATCH, ERASE)
  - the TRANSPARENT constant 8'h00
- Sub-module linebuf_bank: a 512x8 RAM with one synchronous write port and one registered read port, instantiated twice. Write-port muxing selects renderer or erase per bank role.

## Test plan
- Reset, then write bank A addr 0x010 = 0x5A, line_sync, pix_ce with hpix 0x010 -> pixel_out 0x5A and pixel_valid at cycle 2; a later re-read of 0x010 returns 0x00.
- Write 0x07 (colour nibble 0) at addr 0x020, swap, read -> pixel_out 0x00; blank=1 on a stored 0x93 -> 0x00 output and location still erased.
- line_sync issued at cycle 1 of a read sequence -> draw_bank toggles only after ERASE completes, exactly once even with a second pulse at cycle 2.
- pix_ce at cycle 0 and again at cycle 2 -> second ignored, overrun = 1 and stays 1 until nRESET.
- With SPR_LB_FLIP_EN, screen_flip=1, hpix 0x000 -> reads and erases addr 0x1FF. Without the macro -> reads addr 0x000.
- Concurrent renderer writes to the draw bank during display reads -> display data is unaffected; after the swap, the written values read back exactly.
